// File: rtl/data_mem_unit.sv
// Data-memory stage: 3-cycle word RAM access with byte/half/word lanes.
// Optional access counter enabled by defining DMEM_ACCESS_CNT_EN.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  input  logic [31:0] ALUData,
  input  logic [31:0] writeData,
  output logic [31:0] readDataOut,
  output logic        memStall,
  output logic        misalign,
`ifdef DMEM_ACCESS_CNT_EN
  output logic [15:0] accessCount,
`endif
  output logic        misalignErr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             sgn_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [3:0]       be_d;
  logic [31:0]      wword_d;
  logic [31:0]      word_d;
  logic [31:0]      shift_d;
  logic [31:0]      rdata_d;
  logic             unused_addr;

  assign unused_addr = ^ALUData[31:IDX_W+2];

  assign misalign = memReq &
    (((memSize == 2'b01) & ALUData[0]) |
     (memSize[1] & (ALUData[1:0] != 2'b00)));

  assign memStall = memReq & ~misalign & (state_q != RESP);

  assign readDataOut = rdata_q;
  assign misalignErr = err_q;

  always_comb begin
    be_d    = 4'b1111;
    wword_d = wdata_q;
    case (size_q)
      2'b00: begin
        be_d    = 4'b0001 << off_q;
        wword_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_d    = off_q[1] ? 4'b1100 : 4'b0011;
        wword_d = {2{wdata_q[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wword_d = wdata_q;
      end
    endcase
  end

  always_comb begin
    word_d  = mem_q[idx_q];
    shift_d = word_d >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rdata_d = {{24{sgn_q & shift_d[7]}},
                          shift_d[7:0]};
      2'b01:   rdata_d = {{16{sgn_q & shift_d[15]}},
                          shift_d[15:0]};
      default: rdata_d = word_d;
    endcase
  end

  // Reset held across the ACCESS edge must abort the store.
  always_ff @(posedge CLK) begin
    if (state_q == ACCESS && wr_q && !Reset) begin
      for (int k = 0; k < 4; k++) begin
        if (be_d[k]) mem_q[idx_q][8*k +: 8] <= wword_d[8*k +: 8];
      end
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] cnt_q;
  assign accessCount = cnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 16'd0;
    end else if (state_q == ACCESS && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (misalign) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (memReq && !misalign) begin
            idx_q   <= ALUData[IDX_W+1:2];
            off_q   <= ALUData[1:0];
            size_q  <= memSize;
            sgn_q   <= memSigned;
            wr_q    <= memWrite;
            wdata_q <= writeData;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!wr_q) rdata_q <= rdata_d;
          state_q <= RESP;
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table plus
// hand sequences for misalign, input hold, wrap and reset abort.
module tb_data_mem_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        memReq;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSigned;
  logic [31:0] ALUData;
  logic [31:0] writeData;
  logic [31:0] readDataOut;
  logic        memStall;
  logic        misalign;
  logic        misalignErr;
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] accessCount;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  data_mem_unit #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .memReq     (memReq),
    .memWrite   (memWrite),
    .memSize    (memSize),
    .memSigned  (memSigned),
    .ALUData    (ALUData),
    .writeData  (writeData),
    .readDataOut(readDataOut),
    .memStall   (memStall),
    .misalign   (misalign),
`ifdef DMEM_ACCESS_CNT_EN
    .accessCount(accessCount),
`endif
    .misalignErr(misalignErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t v[17];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the next IDLE.
  task automatic access(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd,
                        output int stalls,
                        output logic [31:0] rd);
    memReq    = 1'b1;
    memWrite  = w;
    memSize   = sz;
    memSigned = sg;
    ALUData   = a;
    writeData = wd;
    stalls    = 0;
    #1;
    while (memStall && stalls < 6) begin
      stalls++;
      @(negedge CLK);
      #1;
    end
    rd     = readDataOut;
    memReq = 1'b0;
    @(negedge CLK);
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    v[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0};
    v[1]  = '{1'b0, 2'b10, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF};
    v[2]  = '{1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 32'hDEADBEEF};
    v[3]  = '{1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'h00000011};
    v[4]  = '{1'b1, 2'b00, 1'b0, 32'h21,  32'hABCDEFFF, 32'h00000011};
    v[5]  = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h1122FF44};
    v[6]  = '{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'hFFFFFFFF};
    v[7]  = '{1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'h000000FF};
    v[8]  = '{1'b1, 2'b10, 1'b0, 32'h30,  32'hAAAABBBB, 32'h000000FF};
    v[9]  = '{1'b1, 2'b01, 1'b0, 32'h32,  32'h12348001, 32'h000000FF};
    v[10] = '{1'b0, 2'b01, 1'b1, 32'h32,  32'h0,        32'hFFFF8001};
    v[11] = '{1'b0, 2'b01, 1'b0, 32'h32,  32'h0,        32'h00008001};
    v[12] = '{1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        32'h8001BBBB};
    v[13] = '{1'b0, 2'b01, 1'b1, 32'h30,  32'h0,        32'hFFFFBBBB};
    v[14] = '{1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'h1122FF44};
    v[15] = '{1'b1, 2'b10, 1'b0, 32'h408, 32'h00000005, 32'h1122FF44};
    v[16] = '{1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h00000005};

    Reset     = 1'b1;
    memReq    = 1'b0;
    memWrite  = 1'b0;
    memSize   = 2'b00;
    memSigned = 1'b0;
    ALUData   = 32'h0;
    writeData = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("rst_rd", readDataOut, 32'h0);
    check("rst_err", {31'd0, misalignErr}, 32'h0);
    check("rst_stall", {31'd0, memStall}, 32'h0);
`ifdef DMEM_ACCESS_CNT_EN
    check("rst_cnt", {16'd0, accessCount}, 32'h0);
`endif
    @(negedge CLK);

    for (int i = 0; i < 17; i++) begin
      access(v[i].w, v[i].sz, v[i].sg, v[i].a, v[i].wd, st, rd);
      check($sformatf("vec%0d_stall", i), st, 32'd2);
      check($sformatf("vec%0d_rd", i), rd, v[i].exp);
    end

    // Inputs dropped/changed in ACCESS must not disturb the latched load.
    memReq    = 1'b1;
    memWrite  = 1'b0;
    memSize   = 2'b10;
    memSigned = 1'b0;
    ALUData   = 32'h10;
    @(negedge CLK);
    memReq  = 1'b0;
    ALUData = 32'h20;
    @(negedge CLK);
    #1;
    check("hold_rd", readDataOut, 32'hDEADBEEF);
    @(negedge CLK);

    access(1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, st, rd);
    memReq    = 1'b1;
    memWrite  = 1'b1;
    memSize   = 2'b10;
    ALUData   = 32'h41;
    writeData = 32'hFFFFFFFF;
    #1;
    check("mis_flag", {31'd0, misalign}, 32'h1);
    check("mis_stall", {31'd0, memStall}, 32'h0);
    check("mis_err_pre", {31'd0, misalignErr}, 32'h0);
    @(negedge CLK);
    check("mis_err_set", {31'd0, misalignErr}, 32'h1);
    check("mis_rd", readDataOut, 32'hDEADBEEF);
    memReq = 1'b0;
    @(negedge CLK);
    check("mis_err_hold", {31'd0, misalignErr}, 32'h1);
    memReq  = 1'b1;
    memSize = 2'b01;
    ALUData = 32'h43;
    #1;
    check("mis_half", {31'd0, misalign}, 32'h1);
    memReq = 1'b0;
    @(negedge CLK);
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, st, rd);
    check("mis_nowrite", rd, 32'h01020304);
    check("mis_next_stall", st, 32'd2);

    // Reset during ACCESS of sw 0x9 @0x8 aborts the store.
    memReq    = 1'b1;
    memWrite  = 1'b1;
    memSize   = 2'b10;
    ALUData   = 32'h8;
    writeData = 32'h9;
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    check("abort_rd", readDataOut, 32'h0);
    check("abort_err", {31'd0, misalignErr}, 32'h0);
    memReq = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, st, rd);
    check("abort_keep", rd, 32'h00000005);

`ifdef DMEM_ACCESS_CNT_EN
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, st, rd);
    memReq  = 1'b1;
    memSize = 2'b10;
    ALUData = 32'h41;
    @(negedge CLK);
    memReq = 1'b0;
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, st, rd);
    check("cnt_three", {16'd0, accessCount}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
